// File: rtl/pcs_pkg.sv
// Shared definitions for the PCS transmit path.
//   IDLE_BLK  : 64b/66b control block payload carrying eight /I/ codes
//   SYNC_DATA : sync header for data blocks
//   SYNC_CTRL : sync header for control blocks
//   SEQ_MAX   : last value of the GT TXSEQUENCE counter (pause slot)
//   blk_t     : 66-bit encoded block, header in the upper two bits
package pcs_pkg;

   localparam logic [63:0] IDLE_BLK  = 64'h0000_0000_0000_001E;
   localparam logic [1:0]  SYNC_DATA = 2'b01;
   localparam logic [1:0]  SYNC_CTRL = 2'b10;
   localparam logic [6:0]  SEQ_MAX   = 7'd32;

   typedef struct packed {
      logic [1:0]  hdr;
      logic [63:0] data;
   } blk_t;

endpackage

// File: rtl/pcs_tx_scheduler.sv
// Feeds 66-bit encoded blocks to a 32-bit GT gearbox as two half-blocks,
// driving the GT TXSEQUENCE counter and substituting idle blocks when the
// encoder has nothing to send.
// Ports:
//   i_clk, i_reset_n   : clock, synchronous active-low reset
//   i_blk_data/hdr     : encoded block from the encoder (lane 0 in bits 7:0)
//   i_blk_valid        : encoder block available
//   o_blk_ready        : block is taken this cycle
//   i_gt_tx_ready      : GT TX reset done
//   o_tx_data          : half-block to the scrambler/gearbox
//   o_tx_hdr           : header of the current block
//   o_tx_hdr_valid     : o_tx_hdr is meaningful this cycle (lower half slot)
//   o_tx_sequence      : GT TXSEQUENCE value
//   o_idle_ins         : pulse, idle block was substituted
//   o_idle_cnt         : saturating count of substituted idle blocks
module pcs_tx_scheduler
   import pcs_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [63:0] i_blk_data,
   input  logic [1:0]  i_blk_hdr,
   input  logic        i_blk_valid,
   output logic        o_blk_ready,
   input  logic        i_gt_tx_ready,
   output logic [31:0] o_tx_data,
   output logic [1:0]  o_tx_hdr,
   output logic        o_tx_hdr_valid,
   output logic [6:0]  o_tx_sequence,
   output logic        o_idle_ins,
   output logic [15:0] o_idle_cnt
);

   generate
      if (DATA_WIDTH != 32) begin : g_bad_width
         $error("pcs_tx_scheduler: DATA_WIDTH must be 32");
      end
   endgenerate

   localparam blk_t IDLE_HOLD = '{hdr: SYNC_CTRL, data: IDLE_BLK};

   logic [6:0] seq;
   blk_t       hold;
   logic       pause;

   // Blocks are taken in odd slots so that the lower half goes out in the
   // following even slot; slot 32 is the gearbox pause.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         seq        <= '0;
         hold       <= IDLE_HOLD;
         o_idle_ins <= 1'b0;
         o_idle_cnt <= '0;
      end else if (!i_gt_tx_ready) begin
         seq        <= '0;
         hold       <= IDLE_HOLD;
         o_idle_ins <= 1'b0;
      end else begin
         seq        <= (seq == SEQ_MAX) ? '0 : seq + 7'd1;
         o_idle_ins <= 1'b0;
         if (seq[0]) begin
            if (i_blk_valid) begin
               hold <= '{hdr: i_blk_hdr, data: i_blk_data};
            end else begin
               hold       <= IDLE_HOLD;
               o_idle_ins <= 1'b1;
               if (o_idle_cnt != '1) begin
                  o_idle_cnt <= o_idle_cnt + 16'd1;
               end
            end
         end
      end
   end

   assign pause          = (seq == SEQ_MAX);
   assign o_blk_ready    = i_gt_tx_ready & seq[0];
   assign o_tx_sequence  = seq;
   assign o_tx_hdr       = hold.hdr;
   assign o_tx_hdr_valid = ~seq[0] & ~pause;
   assign o_tx_data      = (seq[0] | pause) ? hold.data[63:32] : hold.data[31:0];

endmodule

// File: tb/tb_pcs_tx_scheduler.sv
// Self-checking bench for pcs_tx_scheduler: directed phases with random
// traffic, compared against a slot-based reference model.
module tb_pcs_tx_scheduler;
   import pcs_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] blk_data;
   logic [1:0]  blk_hdr;
   logic        blk_valid;
   logic        blk_ready;
   logic        gt_tx_ready;
   logic [31:0] tx_data;
   logic [1:0]  tx_hdr;
   logic        tx_hdr_valid;
   logic [6:0]  tx_sequence;
   logic        idle_ins;
   logic [15:0] idle_cnt;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // reference model: slot position is simply cycles-since-start mod 33
   int unsigned m_run;
   logic [65:0] m_hold;
   logic        m_ins;
   logic [15:0] m_cnt;

   localparam logic [65:0] IDLE66 = {2'b10, 64'h0000_0000_0000_001E};

   pcs_tx_scheduler #(.DATA_WIDTH(32)) dut (
      .i_clk          (clk),
      .i_reset_n      (reset_n),
      .i_blk_data     (blk_data),
      .i_blk_hdr      (blk_hdr),
      .i_blk_valid    (blk_valid),
      .o_blk_ready    (blk_ready),
      .i_gt_tx_ready  (gt_tx_ready),
      .o_tx_data      (tx_data),
      .o_tx_hdr       (tx_hdr),
      .o_tx_hdr_valid (tx_hdr_valid),
      .o_tx_sequence  (tx_sequence),
      .o_idle_ins     (idle_ins),
      .o_idle_cnt     (idle_cnt)
   );

   always #5 clk = ~clk;

   function automatic int unsigned m_seq();
      return m_run % 33;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (slot %0d)", tag, obs, exp, m_seq());
      end
   endtask

   task automatic check_outputs();
      int unsigned s;
      logic        lower;
      s = m_seq();
      lower = (s % 2 == 0) && (s != 32);
      chk("seq",       64'(tx_sequence), 64'(s));
      chk("tx_data",   64'(tx_data), lower ? 64'(m_hold[31:0]) : 64'(m_hold[63:32]));
      chk("tx_hdr",    64'(tx_hdr), 64'(m_hold[65:64]));
      chk("hdr_valid", 64'(tx_hdr_valid), 64'(lower));
      chk("idle_ins",  64'(idle_ins), 64'(m_ins));
      chk("idle_cnt",  64'(idle_cnt), 64'(m_cnt));
   endtask

   // one clock: drive at negedge, check ready, clock, update model, check
   task automatic cycle(input logic rst_n, input logic rdy, input logic vld,
                        input logic [1:0] hdr, input logic [63:0] data);
      reset_n     = rst_n;
      gt_tx_ready = rdy;
      blk_valid   = vld;
      blk_hdr     = hdr;
      blk_data    = data;
      #1;
      chk("blk_ready", 64'(blk_ready), 64'(rdy && (m_seq() % 2 == 1)));
      @(posedge clk);
      if (!rst_n) begin
         m_run = 0; m_hold = IDLE66; m_ins = 1'b0; m_cnt = '0;
      end else if (!rdy) begin
         m_run = 0; m_hold = IDLE66; m_ins = 1'b0;
      end else begin
         m_ins = 1'b0;
         if (m_seq() % 2 == 1) begin
            if (vld) m_hold = {hdr, data};
            else begin
               m_hold = IDLE66;
               m_ins  = 1'b1;
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
         end
         m_run = m_run + 1;
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic rand_cycle(input logic rdy);
      cycle(1'b1, rdy, 1'($urandom), 2'($urandom_range(1, 2)), {$urandom, $urandom});
   endtask

   initial begin
      reset_n = 1'b0; gt_tx_ready = 1'b1; blk_valid = 1'b0;
      blk_hdr = 2'b01; blk_data = '0;
      m_run = 0; m_hold = IDLE66; m_ins = 1'b0; m_cnt = '0;
      @(posedge clk);
      @(negedge clk);

      // reset state
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 2'b01, '0);
      chk("rst_data", 64'(tx_data), 64'h0000_001E);
      chk("rst_hdr_valid", 64'(tx_hdr_valid), 64'd1);

      // idle-only run after reset release
      for (int i = 0; i < 33; i++) cycle(1'b1, 1'b1, 1'b0, 2'b01, '0);
      chk("idle_cnt_33", 64'(idle_cnt), 64'd16);

      // continuous valid data blocks, with latency checks around the pause
      cycle(1'b0, 1'b1, 1'b0, 2'b01, '0);
      for (int i = 0; i < 70; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 2'b01, 64'h1122_3344_5566_7788);
         if (m_seq() == 2) chk("lat_lo", 64'(tx_data), 64'h5566_7788);
         if (m_seq() == 3) chk("lat_hi", 64'(tx_data), 64'h1122_3344);
         if (m_seq() == 32) chk("pause_hv", 64'(tx_hdr_valid), 64'd0);
      end
      chk("data_cnt0", 64'(idle_cnt), 64'd0);

      // random traffic with occasional GT not-ready
      for (int i = 0; i < 300; i++) rand_cycle($urandom_range(0, 9) != 0);

      // GT ready drop at slot 17 for 5 cycles, then resume from slot 0
      for (int i = 0; i < 80 && m_seq() != 17; i++) rand_cycle(1'b1);
      for (int i = 0; i < 5; i++) rand_cycle(1'b0);
      for (int i = 0; i < 40; i++) rand_cycle(1'b1);

      // saturation of the idle counter
      cycle(1'b1, 1'b0, 1'b0, 2'b01, '0);
      force dut.o_idle_cnt = 16'hFFFE;
      @(posedge clk);
      #1;
      release dut.o_idle_cnt;
      m_cnt = 16'hFFFE;
      @(negedge clk);
      check_outputs();
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 2'b01, '0);
      chk("sat_ffff", 64'(idle_cnt), 64'hFFFF);

      // reset mid-operation with a data block held
      for (int i = 0; i < 40 && m_seq() != 9; i++)
         cycle(1'b1, 1'b1, 1'b1, 2'b01, 64'hCAFE_F00D_DEAD_BEEF);
      cycle(1'b0, 1'b1, 1'b1, 2'b01, 64'hCAFE_F00D_DEAD_BEEF);
      chk("rst_mid_data", 64'(tx_data), 64'h0000_001E);
      chk("rst_mid_cnt", 64'(idle_cnt), 64'd0);
      for (int i = 0; i < 40; i++) rand_cycle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pcs_tx_scheduler.md
PCS_TX_SCHEDULER -- requirements
Module: pcs_tx_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: i_clk input 1 (rising-edge clock), i_reset_n input 1 (synchronous, active-low).
REQ-002 The block SHALL expose these ports:
- i_blk_data  input  64: encoded 64b/66b block payload from the encoder, lane 0 in bits 7:0
- i_blk_hdr  input  2: sync header, 2'b01 data, 2'b10 control
- i_blk_valid  input  1: encoder block available
- o_blk_ready  output  1: scheduler accepts the block this cycle
- i_gt_tx_ready  input  1: GTY TX reset done
- o_tx_data  output  32: half-block to the 32-bit scrambler/gearbox
- o_tx_hdr  output  2: header of the current block
- o_tx_hdr_valid  output  1: o_tx_hdr is meaningful this cycle
- o_tx_sequence  output  7: GTY TXSEQUENCE value
- o_idle_ins  output  1: one-cycle pulse when an idle block was substituted
- o_idle_cnt  output  16: saturating count of substituted idle blocks
REQ-003 The block SHALL have one parameter: DATA_WIDTH, default 32, the GT data width; 32 is the only legal value and any other value SHALL fail elaboration.

Function
REQ-004 Sequence counter seq (7 bit) SHALL drive o_tx_sequence directly, count 0..32 and wrap 32->0, advancing one per cycle while i_gt_tx_ready=1.
REQ-005 With i_gt_tx_ready=0, seq SHALL hold at 0, o_blk_ready=0, and the hold register SHALL be loaded with IDLE_BLK/2'b10 every cycle.
REQ-006 o_blk_ready SHALL be combinational: 1 iff i_gt_tx_ready=1 and seq is odd (1,3,...,31); it SHALL NOT depend on i_blk_valid.
REQ-007 On a rising edge ending a cycle where seq is odd and i_gt_tx_ready=1:
- if i_blk_valid=1, the 66-bit hold register SHALL load {i_blk_hdr, i_blk_data};
- otherwise it SHALL load {2'b10, IDLE_BLK}, and o_idle_ins SHALL be 1 in the following cycle.
REQ-008 The hold register SHALL be unchanged on all other edges, including seq=32.
REQ-009 Output mux (combinational from the hold register and seq):
- seq even, 0..30: o_tx_data = hold[31:0], o_tx_hdr_valid=1.
- seq odd: o_tx_data = hold[63:32], o_tx_hdr_valid=0.
- seq=32 (pause): o_tx_data = hold[63:32], o_tx_hdr_valid=0; the gearbox ignores the data.
REQ-010 o_tx_hdr SHALL always equal hold[65:64].
REQ-011 Latency: a block accepted in the cycle with seq=k SHALL have its lower half on o_tx_data in the next cycle with seq even, which is k+1, or 0 when k=31 because of the intervening pause.
REQ-012 Over any 33 consecutive cycles with i_gt_tx_ready=1, exactly 16 blocks SHALL be consumed, either accepted or idle-substituted.
REQ-013 o_idle_cnt SHALL increment by 1 on each substitution and saturate at 16'hFFFF; it SHALL NOT increment while i_gt_tx_ready=0.
REQ-014 A fall of i_gt_tx_ready mid-block SHALL abandon the current block; the block SHALL NOT be replayed, and the encoder is responsible for frame integrity.
REQ-015 A block SHALL be considered transferred only when o_blk_ready and i_blk_valid are both 1 in the same cycle; upstream SHALL hold data stable until transfer.

Reset
REQ-016 While i_reset_n=0 at a rising edge: seq=0, hold={2'b10, IDLE_BLK}, o_idle_ins=0, o_idle_cnt=0.
REQ-017 Resulting outputs during and after reset: o_blk_ready=0 while in reset, o_tx_sequence=0, o_tx_data=IDLE_BLK[31:0], o_tx_hdr=2'b10, o_tx_hdr_valid=1.
REQ-018 Reset mid-operation SHALL discard the held block with no partial output afterward.

Structure
REQ-019 pcs_pkg SHALL hold these shared definitions:
- IDLE_BLK = 64'h0000_0000_0000_001E (type 0x1E, eight /I/ codes 7'h00)
- SYNC_DATA = 2'b01 and SYNC_CTRL = 2'b10
- SEQ_MAX = 32
- the 66-bit block typedef
REQ-020 No sub-module SHALL be used; the counter, hold register, and mux are flat in pcs_tx_scheduler.

Verification
REQ-021 Reset release with i_gt_tx_ready=1 and i_blk_valid=0 -> o_tx_data alternates 32'h0000001E / 32'h00000000, o_idle_ins pulses every odd seq, and o_idle_cnt=16 after 33 cycles.
REQ-022 Continuous valid blocks {01, 64'h1122334455667788} -> seq=k odd accept, then 32'h55667788 with hdr_valid=1 at k+1 and 32'h11223344 at k+2; o_idle_cnt stays 0.
REQ-023 Block offered at seq=31 -> seq=32 shows pause (hdr_valid=0, data unchanged), and the block's lower half appears at seq=0.
REQ-024 i_gt_tx_ready dropped at seq=17 for 5 cycles -> seq holds 0, o_blk_ready=0, idle output, no count increments; resume at seq 0.
REQ-025 Force o_idle_cnt to 16'hFFFE and starve the input for 3 blocks -> count reaches 16'hFFFF and holds.
REQ-026 Assert i_reset_n=0 at seq=9 with a data block held -> next cycle seq=0, idle block output, o_idle_cnt=0.
